// File: rtl/crt_pkg.sv
// Shared types and default sizing for the CRT job scheduler.
package crt_pkg;

  localparam int NUM_LANES_DEF   = 4;
  localparam int LANE_W_DEF      = 4;
  localparam int ENG_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } crt_state_e;

  typedef logic [NUM_LANES_DEF-1:0][LANE_W_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/crt_operand_check.sv
// Per-lane operand sanity check (m >= 2 and x < m); only built when
// CRT_SCHED_CHECK_EN is defined.
`ifdef CRT_SCHED_CHECK_EN
module crt_operand_check
  import crt_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int LANE_W    = LANE_W_DEF
) (
  input  logic [NUM_LANES*LANE_W-1:0] m,
  input  logic [NUM_LANES*LANE_W-1:0] x,
  output logic                        err
);

  logic [NUM_LANES-1:0] lane_bad;

  // Flag each lane whose modulus is degenerate or whose residue is out of range.
  always_comb begin
    lane_bad = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bad[i] = (m[i*LANE_W +: LANE_W] < LANE_W'(2)) |
                    (x[i*LANE_W +: LANE_W] >= m[i*LANE_W +: LANE_W]);
    end
  end

  assign err = |lane_bad;

endmodule
`endif

// File: rtl/crt_scheduler.sv
// Two-requester round-robin front end for a fixed-latency CRT engine.
// Define CRT_SCHED_CHECK_EN to reject malformed jobs at grant (out_err = 1).
module crt_scheduler
  import crt_pkg::*;
#(
  parameter int NUM_LANES   = NUM_LANES_DEF,
  parameter int LANE_W      = LANE_W_DEF,
  parameter int ENG_LATENCY = ENG_LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic                        req1_valid,
  output logic                        req0_ready,
  output logic                        req1_ready,
  input  logic [NUM_LANES*LANE_W-1:0] req0_m,
  input  logic [NUM_LANES*LANE_W-1:0] req1_m,
  input  logic [NUM_LANES*LANE_W-1:0] req0_x,
  input  logic [NUM_LANES*LANE_W-1:0] req1_x,
  output logic [NUM_LANES*LANE_W-1:0] eng_m,
  output logic [NUM_LANES*LANE_W-1:0] eng_x,
  input  logic [NUM_LANES*LANE_W-1:0] eng_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*LANE_W-1:0] out_result,
  output logic                        out_id,
  output logic                        out_err,
  output logic                        busy
);

  localparam int         VW       = NUM_LANES * LANE_W;
  localparam logic [3:0] CNT_INIT = 4'(ENG_LATENCY - 1);

  crt_state_e    state;
  crt_state_e    state_nxt;
  logic          rr_ptr;
  logic [3:0]    cnt;
  logic [VW-1:0] hold_m;
  logic [VW-1:0] hold_x;
  logic [VW-1:0] res_val;
  logic          res_id;
  logic          res_err;
  logic          req_any;
  logic          grant_id;
  logic [VW-1:0] sel_m;
  logic [VW-1:0] sel_x;
  logic          chk_err;

`ifdef CRT_SCHED_CHECK_EN
  crt_operand_check #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_check (
    .m   (sel_m),
    .x   (sel_x),
    .err (chk_err)
  );
`else
  assign chk_err = 1'b0;
`endif

  // Arbitration: rr_ptr breaks ties, a lone requester wins outright; nothing is offered in reset.
  always_comb begin
    req_any = reset & (req0_valid | req1_valid);
    if (req0_valid && req1_valid) begin
      grant_id = rr_ptr;
    end else begin
      grant_id = req1_valid;
    end
    sel_m = grant_id ? req1_m : req0_m;
    sel_x = grant_id ? req1_x : req0_x;
  end

  // Next-state and combinational ready for the granted requester.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = chk_err ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job capture, latency countdown, result capture and round-robin update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= 1'b0;
      cnt     <= 4'd0;
      hold_m  <= {VW{1'b0}};
      hold_x  <= {VW{1'b0}};
      res_val <= {VW{1'b0}};
      res_id  <= 1'b0;
      res_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            hold_m  <= sel_m;
            hold_x  <= sel_x;
            res_id  <= grant_id;
            res_err <= chk_err;
            res_val <= {VW{1'b0}};
            cnt     <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            res_val <= eng_result;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            rr_ptr <= ~res_id;
          end
        end
        default: begin
          rr_ptr <= rr_ptr;
        end
      endcase
    end
  end

  assign eng_m      = hold_m;
  assign eng_x      = hold_x;
  assign out_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign out_result = res_val;
  assign out_id     = res_id;
  assign out_err    = res_err;

endmodule

// File: tb/tb_crt_scheduler.sv
// Directed-vector bench for crt_scheduler with a behavioural CRT engine model.
module tb_crt_scheduler;

  localparam int NL  = 4;
  localparam int LW  = 4;
  localparam int LAT = 3;
  localparam int VW  = NL * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [VW-1:0] req0_m, req0_x, req1_m, req1_x;
  logic [VW-1:0] eng_m, eng_x, eng_result, out_result;
  logic          out_valid, out_ready, out_id, out_err, busy;
  int            nvec = 0;
  int            nerr = 0;

  always #5 clk = ~clk;

  crt_scheduler #(.NUM_LANES(NL), .LANE_W(LW), .ENG_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_m(req0_m), .req1_m(req1_m), .req0_x(req0_x), .req1_x(req1_x),
    .eng_m(eng_m), .eng_x(eng_x), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_id(out_id), .out_err(out_err), .busy(busy)
  );

  // Engine model: brute-force CRT, all ones when no solution exists.
  function automatic logic [VW-1:0] crt_solve(input logic [VW-1:0] m, input logic [VW-1:0] x);
    int  prod, mi, xi;
    bit  ok;
    prod = 1;
    for (int i = 0; i < NL; i++) begin
      mi = int'(m[i*LW +: LW]);
      if (mi == 0) return {VW{1'b1}};
      prod = prod * mi;
    end
    for (int y = 0; y < prod; y++) begin
      ok = 1'b1;
      for (int i = 0; i < NL; i++) begin
        mi = int'(m[i*LW +: LW]);
        xi = int'(x[i*LW +: LW]);
        if ((y % mi) != xi) ok = 1'b0;
      end
      if (ok) return VW'(y);
    end
    return {VW{1'b1}};
  endfunction

  logic [VW-1:0] eng_comb, eng_p0, eng_p1;
  always @* eng_comb = crt_solve(eng_m, eng_x);
  always @(posedge clk) begin
    eng_p0 <= eng_comb;
    eng_p1 <= eng_p0;
  end
  assign eng_result = eng_p1;

  task automatic wait_valid(input bit drop, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (drop) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_m = 16'hB974; req0_x = 16'h0143; req1_m = 16'hB974; req1_x = 16'h1120;
    repeat (2) @(negedge clk);
    nvec++;
    if ({out_valid, busy, req0_ready, req1_ready} !== 4'b0000) begin
      nerr++; $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, busy, req0_ready, req1_ready});
    end
    nvec++;
    if ({out_result, eng_m, eng_x} !== {(3*VW){1'b0}}) begin
      nerr++; $display("FAIL reset_data: got %h/%h/%h expected zeros", out_result, eng_m, eng_x);
    end
    nvec++;
    if ({out_id, out_err} !== 2'b00) begin
      nerr++; $display("FAIL reset_id_err: got %b expected 00", {out_id, out_err});
    end
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b1;
  endtask

  task automatic test_single;
    int lat;
    @(negedge clk);
    req0_m = 16'hB974; req0_x = 16'h0143; req0_valid = 1'b1;
    #1;
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    wait_valid(1'b1, lat);
    nvec++;
    if (lat !== LAT + 1) begin
      nerr++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT + 1);
    end
    nvec++;
    if ({out_result, out_id, out_err} !== {16'h04DB, 2'b00}) begin
      nerr++; $display("FAIL single_result: got %h id %b err %b expected 04DB id 0 err 0", out_result, out_id, out_err);
    end
    nvec++;
    if ({eng_m, eng_x} !== {16'hB974, 16'h0143}) begin
      nerr++; $display("FAIL single_eng_ops: got %h/%h expected B974/0143", eng_m, eng_x);
    end
    @(negedge clk);
    nvec++;
    if ({out_valid, busy} !== 2'b00) begin
      nerr++; $display("FAIL single_release: got %b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_contention;
    int gid[3], rid[3];
    logic [VW-1:0] rres[3];
    logic [VW-1:0] exp_res[3] = '{16'h0064, 16'h07D0, 16'h0064};
    int exp_id[3] = '{0, 1, 0};
    int ng = 0, nr = 0, viol = 0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    req0_m = 16'hB974; req0_x = 16'h1120; req1_m = 16'hB974; req1_x = 16'h9250;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && nr < 3; c++) begin
      #1;
      if (req0_ready && req1_ready) viol++;
      if (busy && (req0_ready || req1_ready)) viol++;
      if (ng < 3 && (req0_ready || req1_ready)) begin gid[ng] = int'(req1_ready); ng++; end
      if (out_valid && nr < 3) begin rid[nr] = int'(out_id); rres[nr] = out_result; nr++; end
      @(negedge clk);
      if (ng == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    nvec++;
    if (nr !== 3 || viol !== 0) begin
      nerr++; $display("FAIL contention_flow: got %0d responses %0d ready faults expected 3 and 0", nr, viol);
    end
    for (int i = 0; i < nr; i++) begin
      nvec++;
      if (gid[i] !== exp_id[i] || rid[i] !== exp_id[i] || rres[i] !== exp_res[i]) begin
        nerr++;
        $display("FAIL contention_%0d: got grant %0d id %0d result %h expected %0d/%0d/%h",
                 i, gid[i], rid[i], rres[i], exp_id[i], exp_id[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    out_ready = 1'b0; req0_m = 16'hB974; req0_x = 16'h5551; req0_valid = 1'b1;
    #1;
    nvec++;
    if (req0_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_ready: got %b expected 1", req0_ready);
    end
    wait_valid(1'b1, lat);
    nvec++;
    if (lat !== LAT + 1) begin
      nerr++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT + 1);
    end
    req1_m = 16'hB974; req1_x = 16'h1120; req1_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      nvec++;
      if ({out_valid, busy, req0_ready, req1_ready} !== 4'b1100) begin
        nerr++; $display("FAIL bp_ctrl_%0d: got %b expected 1100", j, {out_valid, busy, req0_ready, req1_ready});
      end
      nvec++;
      if ({out_result, out_id} !== {16'h0005, 1'b0}) begin
        nerr++; $display("FAIL bp_hold_%0d: got %h id %b expected 0005 id 0", j, out_result, out_id);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if ({out_valid, busy} !== 2'b00) begin
      nerr++; $display("FAIL bp_release: got %b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid_wait;
    int lat, seen = 0;
    @(negedge clk);
    req1_m = 16'hB974; req1_x = 16'hA863; req1_valid = 1'b1;
    #1;
    nvec++;
    if (req1_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_wait_grant: got %b expected 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    reset = 1'b0;
    #1;
    nvec++;
    if ({out_valid, busy, out_id, out_err, out_result, eng_m, eng_x} !== {4'b0000, {(3*VW){1'b0}}}) begin
      nerr++; $display("FAIL rst_wait_clear: got %b %h %h %h expected all zero",
                       {out_valid, busy, out_id, out_err}, out_result, eng_m, eng_x);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nerr++; $display("FAIL rst_wait_no_resp: got %0d response cycles expected 0", seen);
    end
    req0_m = 16'hB974; req0_x = 16'h0143; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++; $display("FAIL rst_wait_rr: got %b expected 10", {req0_ready, req1_ready});
    end
    wait_valid(1'b1, lat);
    nvec++;
    if (lat !== LAT + 1 || out_result !== 16'h04DB || out_id !== 1'b0) begin
      nerr++; $display("FAIL rst_wait_next: got lat %0d result %h id %b expected %0d 04DB 0", lat, out_result, out_id, LAT + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_check;
    int lat;
    logic [VW-1:0] cm[2] = '{16'hB971, 16'hB974};
    logic [VW-1:0] cx[2] = '{16'h0140, 16'h0193};
`ifdef CRT_SCHED_CHECK_EN
    logic [VW-1:0] er[2] = '{16'h0000, 16'h0000};
    int el = 1;
    logic ee = 1'b1;
`else
    logic [VW-1:0] er[2] = '{16'h0226, 16'hFFFF};
    int el = LAT + 1;
    logic ee = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0_m = cm[i]; req0_x = cx[i]; req0_valid = 1'b1; out_ready = 1'b1;
      #1;
      nvec++;
      if (req0_ready !== 1'b1) begin
        nerr++; $display("FAIL check_%0d_ready: got %b expected 1", i, req0_ready);
      end
      wait_valid(1'b1, lat);
      nvec++;
      if (lat !== el || out_err !== ee || out_result !== er[i]) begin
        nerr++; $display("FAIL check_%0d: got lat %0d err %b result %h expected %0d %b %h",
                         i, lat, out_err, out_result, el, ee, er[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [VW-1:0] bx[3] = '{16'hA863, 16'h5551, 16'h9250};
    logic [VW-1:0] br[3] = '{16'h0AD3, 16'h0005, 16'h07D0};
    int g[3];
    int ng = 0, nr = 0;
    bit adv = 1'b0;
    @(negedge clk);
    req1_m = 16'hB974; req1_x = bx[0]; req1_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && nr < 3; c++) begin
      #1;
      if (out_valid === 1'b1 && nr < 3) begin
        nvec++;
        if (out_result !== br[nr] || out_err !== 1'b0 || out_id !== 1'b1) begin
          nerr++; $display("FAIL b2b_result_%0d: got %h err %b id %b expected %h 0 1", nr, out_result, out_err, out_id, br[nr]);
        end
        nr++;
      end
      if (req1_ready === 1'b1 && ng < 3) begin g[ng] = c; ng++; adv = 1'b1; end
      @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (ng < 3) req1_x = bx[ng];
        else req1_valid = 1'b0;
      end
    end
    nvec++;
    if (nr !== 3 || ng !== 3) begin
      nerr++; $display("FAIL b2b_count: got %0d grants %0d responses expected 3 and 3", ng, nr);
    end
    // Inclusive span from one grant to the next: grant, LAT WAIT, RESP, IDLE(grant).
    for (int i = 1; i < ng; i++) begin
      nvec++;
      if (g[i] - g[i-1] + 1 !== LAT + 3) begin
        nerr++; $display("FAIL b2b_spacing_%0d: got %0d expected %0d", i, g[i] - g[i-1] + 1, LAT + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
    test_check();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
